// File: rtl/mipi_csi2_capture_ctrl.sv
// Frame capture sequencer between a CSI-2 deserializer and downstream image
// logic. Owns the deserializer enable, passes only whole frames, checks line
// and frame geometry, counts frames and recovers a stalled link.
module mipi_csi2_capture_ctrl #(
  parameter int DATA_WIDTH     = 8,
  parameter int TO_WIDTH       = 24,
  parameter int RECOVER_CYCLES = 64
) (
  input  logic                  img_clk,
  input  logic                  resetb,
  input  logic                  start,
  input  logic                  stop,
  input  logic                  continuous,
  input  logic [7:0]            num_frames,
  input  logic [15:0]           exp_width,
  input  logic [15:0]           exp_height,
  input  logic [TO_WIDTH-1:0]   timeout,
  input  logic                  clear_err,
  input  logic [DATA_WIDTH-1:0] des_dato,
  input  logic                  des_dvo,
  input  logic                  des_lvo,
  input  logic                  des_fvo,
  output logic                  des_enable,
  output logic [DATA_WIDTH-1:0] cap_dat,
  output logic                  cap_dv,
  output logic                  cap_lv,
  output logic                  cap_fv,
  output logic                  busy,
  output logic                  frame_done,
  output logic [15:0]           frame_count,
  output logic                  err_width,
  output logic                  err_height,
  output logic                  err_timeout
);

  localparam int RC_W = $clog2(RECOVER_CYCLES);
  localparam logic [RC_W-1:0] RC_LAST = RC_W'(RECOVER_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, ARM, CAPTURE, RECOVER} state_t;

  state_t              state, state_nxt;
  logic                fvo_d, lvo_d;
  logic                fvo_rise, fvo_fall, lvo_fall, activity;
  logic [15:0]         pix_cnt, line_cnt, line_cnt_end;
  logic [7:0]          run_cnt, nf;
  logic                run_last, stop_pending;
  logic [TO_WIDTH-1:0] wd_cnt;
  logic [RC_W-1:0]     rec_cnt;
  logic                to_hit, pass, frame_end, wd_fire;

  assign fvo_rise = des_fvo & ~fvo_d;
  assign fvo_fall = ~des_fvo & fvo_d;
  assign lvo_fall = ~des_lvo & lvo_d;
  assign activity = des_dvo | (des_lvo ^ lvo_d) | (des_fvo ^ fvo_d);

  // Line count including a line that ends in the same cycle as the frame.
  assign line_cnt_end = (lvo_fall && line_cnt != 16'hFFFF) ? line_cnt + 16'd1 : line_cnt;

  assign nf       = (num_frames == 8'd0) ? 8'd1 : num_frames;
  assign run_last = !continuous && (({1'b0, run_cnt} + 9'd1) >= {1'b0, nf});
  assign to_hit   = (timeout != '0) && (wd_cnt == timeout);

  assign busy       = (state != IDLE);
  assign des_enable = (state == ARM) || (state == CAPTURE);

  // State register.
  // NOTE: sequential state is always written with non-blocking assignments so
  // every register samples the pre-edge values of its neighbours.
  always_ff @(posedge img_clk or negedge resetb) begin
    if (!resetb) state <= IDLE;
    else         state <= state_nxt;
  end

  // Next-state decode plus the per-cycle pass/frame-end/watchdog strobes.
  // NOTE: every signal gets a default first so no path leaves it unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    state_nxt = state;
    pass      = 1'b0;
    frame_end = 1'b0;
    wd_fire   = 1'b0;
    case (state)
      IDLE: if (start && !stop) state_nxt = ARM;
      ARM: begin
        if (stop) begin
          state_nxt = IDLE;
        end else if (fvo_rise) begin
          state_nxt = CAPTURE;
          pass      = 1'b1;
        end else if (to_hit) begin
          state_nxt = RECOVER;
          wd_fire   = 1'b1;
        end
      end
      CAPTURE: begin
        if (to_hit && !activity) begin
          state_nxt = RECOVER;
          wd_fire   = 1'b1;
        end else begin
          pass = 1'b1;
          if (fvo_fall) begin
            frame_end = 1'b1;
            state_nxt = (stop || stop_pending || run_last) ? IDLE : ARM;
          end
        end
      end
      RECOVER: if (rec_cnt == RC_LAST) state_nxt = (stop || stop_pending) ? IDLE : ARM;
      default: state_nxt = IDLE;
    endcase
  end

  // One-cycle delayed copies of the sync signals for edge detection.
  always_ff @(posedge img_clk or negedge resetb) begin
    if (!resetb) begin
      fvo_d <= 1'b0;
      lvo_d <= 1'b0;
    end else begin
      fvo_d <= des_fvo;
      lvo_d <= des_lvo;
    end
  end

  // Gated output register: deserializer outputs delayed one cycle while passing.
  always_ff @(posedge img_clk or negedge resetb) begin
    if (!resetb) begin
      cap_fv  <= 1'b0;
      cap_lv  <= 1'b0;
      cap_dv  <= 1'b0;
      cap_dat <= '0;
    end else begin
      cap_fv <= pass & des_fvo;
      cap_lv <= pass & des_lvo;
      cap_dv <= pass & des_dvo;
      if (pass && des_dvo) cap_dat <= des_dato;
    end
  end

  // Pixel-per-line and line-per-frame counters, restarted at each frame entry.
  always_ff @(posedge img_clk or negedge resetb) begin
    if (!resetb) begin
      pix_cnt  <= '0;
      line_cnt <= '0;
    end else if (state == ARM && pass) begin
      pix_cnt  <= (des_dvo && des_lvo) ? 16'd1 : 16'd0;
      line_cnt <= '0;
    end else if (state == CAPTURE) begin
      if (lvo_fall) begin
        pix_cnt  <= '0;
        line_cnt <= line_cnt_end;
      end else if (des_dvo && des_lvo && pix_cnt != 16'hFFFF) begin
        pix_cnt <= pix_cnt + 16'd1;
      end
    end else begin
      pix_cnt  <= '0;
      line_cnt <= '0;
    end
  end

  // Frame bookkeeping: done pulse, frame/run counters and deferred stop.
  always_ff @(posedge img_clk or negedge resetb) begin
    if (!resetb) begin
      frame_done   <= 1'b0;
      frame_count  <= '0;
      run_cnt      <= '0;
      stop_pending <= 1'b0;
    end else begin
      frame_done <= frame_end;
      if (state == IDLE && state_nxt == ARM) begin
        frame_count <= '0;
        run_cnt     <= '0;
      end else if (frame_end) begin
        frame_count <= frame_count + 16'd1;
        if (run_cnt != 8'hFF) run_cnt <= run_cnt + 8'd1;
      end
      if (state == IDLE) stop_pending <= 1'b0;
      else if (stop && (state == CAPTURE || state == RECOVER)) stop_pending <= 1'b1;
    end
  end

  // Watchdog counts cycles since state entry or last link activity; recovery
  // counter times the enable-low window.
  always_ff @(posedge img_clk or negedge resetb) begin
    if (!resetb) begin
      wd_cnt  <= '0;
      rec_cnt <= '0;
    end else begin
      if (state_nxt != state || (state == CAPTURE && activity)) wd_cnt <= TO_WIDTH'(1);
      else if (wd_cnt != '1)                                    wd_cnt <= wd_cnt + TO_WIDTH'(1);
      if (state != RECOVER) rec_cnt <= '0;
      else                  rec_cnt <= rec_cnt + RC_W'(1);
    end
  end

  // Sticky error flags; a new event wins over a coincident clear.
  always_ff @(posedge img_clk or negedge resetb) begin
    if (!resetb) begin
      err_width   <= 1'b0;
      err_height  <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      err_width   <= (err_width & ~clear_err) |
                     (state == CAPTURE && lvo_fall && pix_cnt != exp_width);
      err_height  <= (err_height & ~clear_err) | (frame_end && line_cnt_end != exp_height);
      err_timeout <= (err_timeout & ~clear_err) | wd_fire;
    end
  end

endmodule

// File: tb/tb_mipi_csi2_capture_ctrl.sv
// Self-checking bench for mipi_csi2_capture_ctrl: a cycle driver generates
// frames, a scoreboard queue holds pixels that must appear on cap_dat, and a
// negedge monitor compares the gated outputs against the delayed inputs.
module tb_mipi_csi2_capture_ctrl;

  localparam int DW  = 8;
  localparam int TOW = 24;
  localparam int RC  = 64;

  logic           img_clk = 1'b0;
  logic           resetb  = 1'b0;
  logic           start = 1'b0, stop = 1'b0, continuous = 1'b0, clear_err = 1'b0;
  logic [7:0]     num_frames = 8'd2;
  logic [15:0]    exp_width = 16'd4, exp_height = 16'd3;
  logic [TOW-1:0] timeout = TOW'(1000);
  logic [DW-1:0]  des_dato = '0;
  logic           des_dvo = 1'b0, des_lvo = 1'b0, des_fvo = 1'b0;
  logic           des_enable, cap_dv, cap_lv, cap_fv, busy, frame_done;
  logic [DW-1:0]  cap_dat;
  logic [15:0]    frame_count;
  logic           err_width, err_height, err_timeout;

  int             checks = 0;
  int             errors = 0;
  int             fd_count = 0;
  bit             mon_en = 1'b0;
  bit             exp_cap = 1'b0;
  bit             prev_exp = 1'b0;
  logic [2:0]     prev_ctl = 3'b000;
  logic [2:0]     exp_ctl;
  logic [DW-1:0]  mon_exp;
  logic [DW-1:0]  exp_q[$];

  mipi_csi2_capture_ctrl #(.DATA_WIDTH(DW), .TO_WIDTH(TOW), .RECOVER_CYCLES(RC)) dut (
    .img_clk(img_clk), .resetb(resetb), .start(start), .stop(stop),
    .continuous(continuous), .num_frames(num_frames), .exp_width(exp_width),
    .exp_height(exp_height), .timeout(timeout), .clear_err(clear_err),
    .des_dato(des_dato), .des_dvo(des_dvo), .des_lvo(des_lvo), .des_fvo(des_fvo),
    .des_enable(des_enable), .cap_dat(cap_dat), .cap_dv(cap_dv), .cap_lv(cap_lv),
    .cap_fv(cap_fv), .busy(busy), .frame_done(frame_done), .frame_count(frame_count),
    .err_width(err_width), .err_height(err_height), .err_timeout(err_timeout)
  );

  always #5 img_clk = ~img_clk;

  // Monitor: cap_* must equal last cycle's des_* when that cycle was expected
  // to pass, otherwise zero; every cap_dv beat pops the scoreboard.
  always @(negedge img_clk) begin
    if (frame_done === 1'b1) fd_count++;
    if (mon_en) begin
      exp_ctl = prev_exp ? prev_ctl : 3'b000;
      checks++;
      if ({cap_fv, cap_lv, cap_dv} !== exp_ctl) begin
        errors++;
        $display("FAIL cap_ctl @%0t: fv/lv/dv=%b expected %b", $time, {cap_fv, cap_lv, cap_dv}, exp_ctl);
      end
      if (cap_dv === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL cap_dat @%0t: got beat %h expected no beat", $time, cap_dat);
        end else begin
          mon_exp = exp_q.pop_front();
          if (cap_dat !== mon_exp) begin
            errors++;
            $display("FAIL cap_dat @%0t: got %h expected %h", $time, cap_dat, mon_exp);
          end
        end
      end
    end
    prev_ctl = {des_fvo, des_lvo, des_dvo};
    prev_exp = exp_cap;
  end

  // One cycle of link stimulus; inputs change 1 time unit after the edge.
  task automatic step(input bit fv, input bit lv, input bit dv, input bit st, input bit sp);
    des_fvo  = fv;
    des_lvo  = lv;
    des_dvo  = dv;
    start    = st;
    stop     = sp;
    des_dato = dv ? DW'($urandom) : '0;
    if (dv && exp_cap) exp_q.push_back(des_dato);
    @(posedge img_clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0);
  endtask

  // Frame: 1 lead cycle, lines of width beats (long_line gets one extra),
  // 2-cycle line gaps, then fvo falls and 3 idle cycles follow.
  task automatic send_frame(input int lines, input int width, input int long_line,
                            input bit expect_cap, input int start_at, input int stop_at);
    int c = 0;
    exp_cap = expect_cap;
    step(1, 0, 0, c == start_at, c == stop_at); c++;
    for (int l = 0; l < lines; l++) begin
      for (int b = 0; b < width + ((l == long_line) ? 1 : 0); b++) begin
        step(1, 1, 1, c == start_at, c == stop_at); c++;
      end
      for (int g = 0; g < 2; g++) begin
        step(1, 0, 0, c == start_at, c == stop_at); c++;
      end
    end
    step(0, 0, 0, c == start_at, c == stop_at);
    exp_cap = 1'b0;
    idle(3);
  endtask

  task automatic check_bit(input string name, input logic got, input logic want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, got, want);
    end
  endtask

  task automatic check_word(input string name, input logic [15:0] got, input logic [15:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, want);
    end
  endtask

  task automatic test_reset();
    check_bit("reset busy", busy, 1'b0);
    check_bit("reset des_enable", des_enable, 1'b0);
    check_bit("reset cap_fv", cap_fv, 1'b0);
    check_word("reset frame_count", frame_count, 16'd0);
    check_bit("reset errors", err_width | err_height | err_timeout, 1'b0);
  endtask

  task automatic test_cmd_priority();
    step(0, 0, 0, 1, 1);
    check_bit("start+stop stays idle", busy, 1'b0);
    step(0, 0, 0, 0, 1);
    check_bit("stop in idle ignored", busy, 1'b0);
  endtask

  task automatic test_single_run();
    int fd0;
    continuous = 1'b0; num_frames = 8'd2;
    fd0 = fd_count;
    step(0, 0, 0, 1, 0);
    check_bit("armed busy", busy, 1'b1);
    check_bit("armed des_enable", des_enable, 1'b1);
    send_frame(3, 4, -1, 1, -1, -1);
    check_bit("busy between frames", busy, 1'b1);
    send_frame(3, 4, -1, 1, -1, -1);
    send_frame(3, 4, -1, 0, -1, -1);
    check_word("single frame_done pulses", 16'(fd_count - fd0), 16'd2);
    check_word("single frame_count", frame_count, 16'd2);
    check_bit("single busy falls", busy, 1'b0);
    check_bit("single des_enable off", des_enable, 1'b0);
    check_bit("single no errors", err_width | err_height | err_timeout, 1'b0);
    check_word("single scoreboard drained", 16'(exp_q.size()), 16'd0);
  endtask

  task automatic test_midframe_start();
    int fd0;
    continuous = 1'b0; num_frames = 8'd1;
    fd0 = fd_count;
    send_frame(3, 4, -1, 0, 5, -1);
    check_word("midframe partial not counted", frame_count, 16'd0);
    send_frame(3, 4, -1, 1, -1, -1);
    check_word("midframe frame_count", frame_count, 16'd1);
    check_word("midframe frame_done pulses", 16'(fd_count - fd0), 16'd1);
    check_bit("midframe busy falls", busy, 1'b0);
  endtask

  task automatic test_geometry_errors();
    continuous = 1'b0; num_frames = 8'd1;
    step(0, 0, 0, 1, 0);
    send_frame(2, 4, 1, 1, -1, -1);
    check_bit("err_width set", err_width, 1'b1);
    check_bit("err_height set", err_height, 1'b1);
    check_bit("geometry no timeout", err_timeout, 1'b0);
    clear_err = 1'b1;
    step(0, 0, 0, 0, 0);
    clear_err = 1'b0;
    check_bit("err_width cleared", err_width, 1'b0);
    check_bit("err_height cleared", err_height, 1'b0);
  endtask

  task automatic test_stop_continuous();
    int fd0;
    continuous = 1'b1;
    fd0 = fd_count;
    step(0, 0, 0, 1, 0);
    send_frame(3, 4, -1, 1, -1, -1);
    send_frame(3, 4, -1, 1, -1, 8);
    check_bit("stop leaves idle", busy, 1'b0);
    send_frame(3, 4, -1, 0, -1, -1);
    check_word("stop frame_done pulses", 16'(fd_count - fd0), 16'd2);
    check_word("stop frame_count", frame_count, 16'd2);
    check_bit("stop des_enable off", des_enable, 1'b0);
    continuous = 1'b0;
  endtask

  task automatic test_timeout();
    int low_cnt = 0;
    int fd0;
    continuous = 1'b0; num_frames = 8'd1; timeout = TOW'(50);
    fd0 = fd_count;
    step(0, 0, 0, 1, 0);
    idle(49);
    check_bit("timeout not early", err_timeout, 1'b0);
    idle(1);
    check_bit("timeout at 50", err_timeout, 1'b1);
    while (des_enable === 1'b0 && low_cnt < 200) begin
      low_cnt++;
      idle(1);
    end
    check_word("recover enable-low cycles", 16'(low_cnt), 16'(RC));
    check_bit("re-armed busy", busy, 1'b1);
    send_frame(3, 4, -1, 1, -1, -1);
    check_word("timeout frame_count", frame_count, 16'd1);
    check_word("timeout frame_done pulses", 16'(fd_count - fd0), 16'd1);
    check_bit("err_timeout sticky", err_timeout, 1'b1);
    timeout = TOW'(1000);
    clear_err = 1'b1;
    step(0, 0, 0, 0, 0);
    clear_err = 1'b0;
    check_bit("err_timeout cleared", err_timeout, 1'b0);
  endtask

  task automatic test_reset_midframe();
    int fd0;
    continuous = 1'b1;
    step(0, 0, 0, 1, 0);
    exp_cap = 1'b1;
    step(1, 0, 0, 0, 0);
    step(1, 1, 1, 0, 0);
    step(1, 1, 1, 0, 0);
    check_bit("capturing before reset", cap_fv, 1'b1);
    mon_en = 1'b0;
    exp_cap = 1'b0;
    #1 resetb = 1'b0;
    #1;
    check_word("async reset outputs",
               {9'd0, cap_fv, cap_lv, cap_dv, des_enable, busy, frame_done, |frame_count},
               16'd0);
    des_fvo = 1'b0; des_lvo = 1'b0; des_dvo = 1'b0;
    #1 resetb = 1'b1;
    exp_q.delete();
    idle(3);
    check_bit("idle after reset", busy, 1'b0);
    check_bit("enable off after reset", des_enable, 1'b0);
    mon_en = 1'b1;
    fd0 = fd_count;
    send_frame(3, 4, -1, 0, -1, -1);
    check_word("no capture without start", 16'(fd_count - fd0), 16'd0);
    continuous = 1'b0;
  endtask

  initial begin
    repeat (3) @(posedge img_clk);
    #1 resetb = 1'b1;
    test_reset();
    idle(1);
    mon_en = 1'b1;
    test_cmd_priority();
    test_single_run();
    test_midframe_start();
    test_geometry_errors();
    test_stop_continuous();
    test_timeout();
    test_reset_midframe();
    idle(2);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mipi_csi2_capture_ctrl.md
Name: mipi_csi2_capture_ctrl

Overview:
- Frame capture sequencer that sits between the CSI-2 deserializer outputs (dato/dvo/lvo/fvo, img_clk domain) and downstream image logic.
- Owns the deserializer `enable`. Arms capture on host command and gates output so only whole frames pass.
- Checks line and frame geometry, counts frames, and runs a watchdog that power-cycles the deserializer enable when the link stalls.

Parameters:
DATA_WIDTH, 8, pixel data width; matches the deserializer dato width
TO_WIDTH, 24, width of the watchdog timeout counter
RECOVER_CYCLES, 64, img_clk cycles des_enable is held low during recovery (must be >=2)

Ports:
img_clk  in  1  pixel/byte clock from deserializer
resetb  in  1  reset
start  in  1  single-cycle pulse: begin capture
stop  in  1  single-cycle pulse: end capture
continuous  in  1  1 = capture until stop; 0 = capture num_frames then stop
num_frames  in  8  frames per single run; 0 is treated as 1
exp_width  in  16  expected pixels (dvo beats) per line
exp_height  in  16  expected lines per frame
timeout  in  TO_WIDTH  watchdog limit in cycles; 0 disables watchdog
clear_err  in  1  pulse: clear sticky error flags
des_dato  in  DATA_WIDTH  deserializer data
des_dvo  in  1  deserializer data valid
des_lvo  in  1  deserializer line valid
des_fvo  in  1  deserializer frame valid
des_enable  out  1  enable to deserializer
cap_dat  out  DATA_WIDTH  gated data
cap_dv  out  1  gated data valid
cap_lv  out  1  gated line valid
cap_fv  out  1  gated frame valid
busy  out  1  high in any state except IDLE
frame_done  out  1  one-cycle pulse at end of each captured frame
frame_count  out  16  frames completed since start; wraps at 65535->0
err_width  out  1  sticky: line pixel count != exp_width
err_height  out  1  sticky: frame line count != exp_height
err_timeout  out  1  sticky: watchdog fired

Behaviour:
- Reset: resetb asynchronous, active-low; clock img_clk.
- All outputs reset to 0; state resets to IDLE. Reset mid-frame drops des_enable and cap_* immediately.
- States:
  - IDLE: des_enable=0.
  - ARM: des_enable=1; waiting for a des_fvo rising edge.
  - CAPTURE: frame passing.
  - RECOVER: des_enable=0 for RECOVER_CYCLES.
- Edges are detected against 1-cycle-delayed copies of des_fvo/des_lvo.
- IDLE -> ARM on start. frame_count and the run counter clear on start.
- ARM:
  - Only a des_fvo rising edge enters CAPTURE. If fvo is already high on entry, wait for it to fall, then rise; partial frames are never passed.
  - stop -> IDLE next cycle.
- CAPTURE:
  - cap_* = des_* registered; 1-cycle latency; cap_dat updates only when des_dvo=1.
  - Pixel counter increments on des_dvo while des_lvo, saturating at 0xFFFF. On des_lvo falling edge: compare to exp_width (mismatch sets err_width), then clear it and increment the line counter (saturating).
  - On des_fvo falling edge: compare line count to exp_height (sets err_height), pulse frame_done, increment frame_count.
    - Next state is IDLE if stop is pending, or if continuous=0 and the run count reaches num_frames (0 treated as 1).
    - Otherwise next state is ARM.
  - stop in CAPTURE sets stop_pending; the frame completes normally.
- Watchdog (timeout!=0):
  - In ARM the counter runs from state entry. In CAPTURE it clears on any des_dvo or des_lvo/des_fvo edge.
  - When the count equals timeout: set err_timeout, force cap_fv/cap_lv/cap_dv low the next cycle (no frame_done, frame_count unchanged), go to RECOVER.
- RECOVER: after RECOVER_CYCLES, go to ARM, or to IDLE if stop_pending or a stop arrived during RECOVER.
- Command priority:
  - start while busy is ignored; stop in IDLE is ignored.
  - start and stop in the same cycle: stop wins (IDLE stays IDLE).
  - clear_err coincident with a new error event: the flag stays set.
- Width and height counters reset at each CAPTURE entry.
- Config inputs are sampled continuously. They must be held stable while busy.

Test Plan:
- continuous=0, num_frames=2, 4x3 frames, timeout=1000, start -> exactly 2 frames on cap_* delayed 1 cycle; 2 frame_done pulses; frame_count=2; busy falls; des_enable=0; no error flags.
- start asserted while des_fvo high mid-frame -> cap_fv stays 0 until the next fvo rise; first captured frame is complete; frame_count increments only for complete frames.
- exp_width=4, one line of 5 beats; exp_height=3, frame of 2 lines -> err_width=1, err_height=1 after the respective falling edges; clear_err clears both.
- continuous=1, stop pulsed mid-frame -> current frame completes with frame_done; then IDLE; no further cap_fv.
- timeout=50, armed with no fvo -> err_timeout at cycle 50; des_enable low exactly RECOVER_CYCLES; re-arms; frame sent afterwards is captured.
- resetb asserted mid-CAPTURE -> all outputs 0 asynchronously; after release, IDLE until start.
